// File: rtl/mc10181_pkg.sv
// rtl/mc10181_pkg.sv - select-code names and P/G vector type for the MC10181 slice
package mc10181_pkg;

  // Select codes packed as {s0, s1, s2, s3}
  localparam logic [3:0] SEL_A         = 4'b0000;
  localparam logic [3:0] SEL_A_PLUS_B  = 4'b1001;
  localparam logic [3:0] SEL_A_MINUS_B = 4'b0110;
  localparam logic [3:0] SEL_AND       = 4'b1101;

  typedef struct packed {
    logic [3:0] p;
    logic [3:0] g;
  } pg_t;

endpackage

// File: rtl/mc10181_cla.sv
// rtl/mc10181_cla.sv - lookahead carry and group propagate/generate for one 4-bit slice
module mc10181_cla
  import mc10181_pkg::*;
(
  input  pg_t        pg,
  input  logic       cin,
  output logic [3:0] carry,
  output logic       cg,
  output logic       cp,
  output logic       cout
);

  assign carry[0] = cin;
  assign carry[1] = pg.g[0] | (pg.p[0] & cin);
  assign carry[2] = pg.g[1] | (pg.p[1] & pg.g[0]) | (pg.p[1] & pg.p[0] & cin);
  assign carry[3] = pg.g[2] | (pg.p[2] & pg.g[1]) | (pg.p[2] & pg.p[1] & pg.g[0])
                  | (pg.p[2] & pg.p[1] & pg.p[0] & cin);

  assign cg = &pg.p;
  assign cp = pg.g[3]
            | (pg.p[3] & pg.g[2])
            | (pg.p[3] & pg.p[2] & pg.g[1])
            | (pg.p[3] & pg.p[2] & pg.p[1] & pg.g[0]);

  // Lookahead form of the carry out of bit 3
  assign cout = cp | (cg & cin);

endmodule

// File: rtl/mc10181_alu.sv
// rtl/mc10181_alu.sv - MC10181 4-bit function generator; MC10181_OUTREG_EN adds an output register
module mc10181_alu
  import mc10181_pkg::*;
(
  input  logic s0,
  input  logic s1,
  input  logic s2,
  input  logic s3,
  input  logic boole,
  input  logic cin,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic f0,
  output logic f1,
  output logic f2,
  output logic f3,
  output logic cg,
  output logic cp,
  output logic cout,
  input  logic clk,
  input  logic reset
);

  logic [3:0] a;
  logic [3:0] b;
  pg_t        pg;
  logic [3:0] carry;
  logic [3:0] f_comb;
  logic       cg_comb;
  logic       cp_comb;
  logic       cout_comb;

  assign a = {a3, a2, a1, a0};
  assign b = {b3, b2, b1, b0};

  assign pg.p = a | ({4{s0}} & b) | ({4{s1}} & ~b);
  assign pg.g = a & (({4{s2}} & ~b) | ({4{s3}} & b));

  mc10181_cla u_cla (
    .pg    (pg),
    .cin   (cin),
    .carry (carry),
    .cg    (cg_comb),
    .cp    (cp_comb),
    .cout  (cout_comb)
  );

  // Logic mode forces every k_i high so the carry chain drops out of F
  assign f_comb = pg.p ^ pg.g ^ (boole ? 4'b1111 : carry);

`ifdef MC10181_OUTREG_EN
  logic [3:0] f_q;
  logic       cg_q;
  logic       cp_q;
  logic       cout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q    <= 4'b0000;
      cg_q   <= 1'b0;
      cp_q   <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      f_q    <= f_comb;
      cg_q   <= cg_comb;
      cp_q   <= cp_comb;
      cout_q <= cout_comb;
    end
  end

  assign {f3, f2, f1, f0} = f_q;
  assign cg   = cg_q;
  assign cp   = cp_q;
  assign cout = cout_q;
`else
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  assign {f3, f2, f1, f0} = f_comb;
  assign cg   = cg_comb;
  assign cp   = cp_comb;
  assign cout = cout_comb;
`endif

endmodule

// File: tb/tb_mc10181_alu.sv
// tb/tb_mc10181_alu.sv - directed-vector bench for mc10181_alu
module tb_mc10181_alu;
  import mc10181_pkg::*;

  logic s0, s1, s2, s3, boole, cin;
  logic a0, a1, a2, a3, b0, b1, b2, b3;
  logic f0, f1, f2, f3, cg, cp, cout;
  logic clk, reset;

  int tests_run;
  int tests_failed;

  mc10181_alu dut (
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .boole(boole), .cin(cin),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .f0(f0), .f1(f1), .f2(f2), .f3(f3),
    .cg(cg), .cp(cp), .cout(cout),
    .clk(clk), .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic [3:0] sel, input logic bl, input logic ci,
                       input logic [3:0] av, input logic [3:0] bv);
    {s0, s1, s2, s3} = sel;
    boole = bl;
    cin   = ci;
    {a3, a2, a1, a0} = av;
    {b3, b2, b1, b0} = bv;
  endtask

  task automatic check(input string tag, input logic [3:0] ef, input logic ecg,
                       input logic ecp, input logic ecout);
    logic [6:0] obs;
    logic [6:0] exp_v;
    obs   = {f3, f2, f1, f0, cg, cp, cout};
    exp_v = {ef, ecg, ecp, ecout};
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed f=%b cg=%b cp=%b cout=%b, expected f=%b cg=%b cp=%b cout=%b",
             tag, obs[6:3], obs[2], obs[1], obs[0], ef, ecg, ecp, ecout);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    apply(SEL_A, 1'b1, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);

`ifndef MC10181_OUTREG_EN
    apply(SEL_A, 1'b1, 1'b0, 4'b1111, 4'b0000); #1 check("not_a_1111_c0", 4'b0000, 1'b1, 1'b0, 1'b0);
    apply(SEL_A, 1'b1, 1'b1, 4'b1111, 4'b0000); #1 check("not_a_1111_c1", 4'b0000, 1'b1, 1'b0, 1'b1);
    apply(SEL_A, 1'b1, 1'b0, 4'b0000, 4'b1111); #1 check("not_a_0000_c0", 4'b1111, 1'b0, 1'b0, 1'b0);
    apply(SEL_A, 1'b1, 1'b1, 4'b0000, 4'b1111); #1 check("not_a_0000_c1", 4'b1111, 1'b0, 1'b0, 1'b0);
    apply(SEL_A, 1'b1, 1'b0, 4'b1010, 4'b1111); #1 check("not_a_1010_c0", 4'b0101, 1'b0, 1'b0, 1'b0);
    apply(SEL_A, 1'b1, 1'b1, 4'b0101, 4'b1111); #1 check("not_a_0101_c1", 4'b1010, 1'b0, 1'b0, 1'b0);

    apply(SEL_A_PLUS_B, 1'b0, 1'b0, 4'b0011, 4'b0101); #1 check("add_3_5", 4'b1000, 1'b0, 1'b0, 1'b0);
    apply(SEL_A_PLUS_B, 1'b0, 1'b0, 4'b1111, 4'b0001); #1 check("add_wrap", 4'b0000, 1'b1, 1'b1, 1'b1);
    apply(SEL_A_PLUS_B, 1'b0, 1'b1, 4'b0100, 4'b0010); #1 check("add_cin", 4'b0111, 1'b0, 1'b0, 1'b0);

    apply(SEL_A_MINUS_B, 1'b0, 1'b1, 4'b0111, 4'b0010); #1 check("sub_7_2", 4'b0101, 1'b1, 1'b1, 1'b1);
    apply(SEL_A_MINUS_B, 1'b0, 1'b0, 4'b0111, 4'b0010); #1 check("sub_7_2_m1", 4'b0100, 1'b1, 1'b1, 1'b1);

    apply(SEL_A, 1'b0, 1'b1, 4'b0111, 4'b0000); #1 check("inc_7", 4'b1000, 1'b0, 1'b0, 1'b0);
    apply(SEL_A, 1'b0, 1'b1, 4'b1111, 4'b0000); #1 check("inc_15", 4'b0000, 1'b1, 1'b0, 1'b1);

    apply(SEL_A_PLUS_B, 1'b1, 1'b0, 4'b0011, 4'b0101); #1 check("xnor", 4'b1001, 1'b0, 1'b0, 1'b0);
    apply(SEL_A_MINUS_B, 1'b1, 1'b0, 4'b0111, 4'b0010); #1 check("xor", 4'b0101, 1'b1, 1'b1, 1'b1);
    apply(SEL_AND, 1'b1, 1'b0, 4'b1100, 4'b1010); #1 check("and", 4'b1000, 1'b1, 1'b1, 1'b1);

    reset = 1'b1;
    #1 check("reset_ignored", 4'b1000, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1 check("clk_ignored", 4'b1000, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
`else
    apply(SEL_AND, 1'b1, 1'b0, 4'b1100, 4'b1010);
    #1 reset = 1'b1;
    #1 check("reg_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("reg_hold", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("reg_and", 4'b1000, 1'b1, 1'b1, 1'b1);
    apply(SEL_A_PLUS_B, 1'b0, 1'b0, 4'b0011, 4'b0101);
    #1 check("reg_latency", 4'b1000, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1 check("reg_add", 4'b1000, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
